machine_p: RTL and testbench
============================

MACHINE_P -- requirements
Module: machine_p

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, meaning pattern length in bits; legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 4'b1101, meaning target bit pattern; bit PAT_LEN-1 is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8, meaning detection counter width; legal range 2..16.
REQ-005 SHALL define local width SW = clog2(PAT_LEN+1).
REQ-006 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-007 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-008 SHALL have port x, input, 1, serial data bit sampled on the rising edge of CLK.
REQ-009 SHALL have port en, input, 1, bit-valid; x is consumed only when en=1.
REQ-010 SHALL have port clr_cnt, input, 1, synchronous clear of count.
REQ-011 SHALL have port F, output, 1, Moore match flag.
REQ-012 SHALL have port S, output, SW, current state, equal to the number of pattern bits currently matched.
REQ-013 SHALL have port count, output, CNT_W, saturating count of detections.

Function
REQ-014 State S SHALL range over 0..PAT_LEN; values above PAT_LEN are unreachable.
REQ-015 For S=k<PAT_LEN with en=1: next S SHALL be the largest j≤k+1 such that the last j bits of (first k pattern bits followed by x) equal the first j pattern bits, or 0 if no such j exists.
REQ-016 For S=PAT_LEN, en=1 and OVERLAP=1: next S SHALL follow the REQ-015 rule on (full pattern followed by x), with j≤PAT_LEN.
REQ-017 For S=PAT_LEN, en=1 and OVERLAP=0: next S SHALL be 1 if x equals PATTERN[PAT_LEN-1], else 0.
REQ-018 With en=0, S, F and count SHALL hold their values regardless of x.
REQ-019 F SHALL be registered and equal (S==PAT_LEN); no combinational path from x to F.
REQ-020 Detection latency: F SHALL rise on the same edge that consumes the last pattern bit.
REQ-021 Under continuous en=1, F SHALL be high for exactly one cycle per detection.
REQ-022 count SHALL increment by 1 on each edge where next S==PAT_LEN and en=1.
REQ-023 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 On clr_cnt=1 without a detection, count SHALL become 0.
REQ-025 On clr_cnt=1 coincident with a detection, count SHALL become 1.
REQ-026 clr_cnt SHALL NOT affect S or F.

Reset
REQ-027 On an edge with RESET=1: S=0, F=0 and count=0.
REQ-028 RESET SHALL override en, x and clr_cnt.
REQ-029 A RESET mid-pattern SHALL discard the partial match; no detection SHALL be counted on the reset edge.
REQ-030 RESET SHALL be ignored between clock edges (no asynchronous effect).

Verification (PAT_LEN=4, PATTERN=1101, en=1 unless stated)
REQ-031 RESET high for one edge, any x -> S=0, F=0, count=0.
REQ-032 OVERLAP=1, x=1,1,0,1,1,0,1 -> S after each edge = 1,2,3,4,2,3,4; F high after edges 4 and 7; count=2.
REQ-033 OVERLAP=0, same stream -> S = 1,2,3,4,1,0,1; F high after edge 4 only; count=1.
REQ-034 Partial-match fallback and en gating:
- x=1,1,1 -> S=1,2,2.
- Then en=0 for 3 edges with x toggling -> S stays 2.
- Then en=1, x=0,1 -> S=3,4.
REQ-035 CNT_W=2 saturation and clear:
- 4 detections -> count=3 and holds.
- clr_cnt alone -> count=0.
- clr_cnt coincident with a detection -> count=1.
REQ-036 Reset mid-pattern: at S=3, RESET=1 with x=1 -> S=0, F=0, count=0; F never asserts on that edge.

Source files
------------

// File: rtl/machine_p.sv
// Serial pattern detector: tracks how many leading pattern bits are currently matched,
// raises a registered match flag and keeps a saturating detection count.
module machine_p #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             x,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             F,
    output logic [SW-1:0]    S,
    output logic [CNT_W-1:0] count
);

    localparam int               NUM_CODES = 2 ** SW;
    localparam logic [SW-1:0]    FULL      = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Transition table for one value of the incoming bit, one SW-bit entry per state code.
    // For each state k the matched prefix is extended by the incoming bit and the longest
    // suffix that is also a pattern prefix becomes the next state. Unreachable codes map to 0.
    function automatic logic [NUM_CODES*SW-1:0] build_table(input logic xb);
        logic [NUM_CODES*SW-1:0] t;
        int pat;
        int seq;
        int best;
        int jmax;
        t   = '0;
        pat = int'(PATTERN);
        for (int k = 0; k <= PAT_LEN; k++) begin
            best = 0;
            if (k == PAT_LEN && OVERLAP == 0) begin
                best = (xb == PATTERN[PAT_LEN-1]) ? 1 : 0;
            end else begin
                jmax = (k < PAT_LEN) ? k + 1 : PAT_LEN;
                seq  = ((pat >> (PAT_LEN - k)) << 1) | int'(xb);
                for (int j = 1; j <= jmax; j++) begin
                    if ((seq & ((1 << j) - 1)) == (pat >> (PAT_LEN - j))) begin
                        best = j;
                    end
                end
            end
            t[k*SW +: SW] = best[SW-1:0];
        end
        return t;
    endfunction

    localparam logic [NUM_CODES*SW-1:0] TBL0 = build_table(1'b0);
    localparam logic [NUM_CODES*SW-1:0] TBL1 = build_table(1'b1);

    logic [SW-1:0]    s_q, s_d;
    logic             f_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        s_d   = x ? TBL1[int'(s_q)*SW +: SW] : TBL0[int'(s_q)*SW +: SW];
        hit   = en && (s_d == FULL);
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = hit ? CNT_ONE : '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from
    // the same pre-edge values; RESET is sampled only here, making it purely synchronous.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_q   <= '0;
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (en) begin
                s_q <= s_d;
                f_q <= (s_d == FULL);
            end
            cnt_q <= cnt_d;
        end
    end

    assign S     = s_q;
    assign F     = f_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_machine_p.sv
// Directed bench for machine_p: overlapping, non-overlapping and 2-bit-counter
// instances share one stimulus stream, each checked against hand-derived values.
module tb_machine_p;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       x = 1'b0;
    logic       en = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       f_ov, f_nov, f_sat;
    logic [2:0] s_ov, s_nov, s_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    machine_p #(.OVERLAP(1)) u_ov (
        .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
        .F(f_ov), .S(s_ov), .count(cnt_ov)
    );

    machine_p #(.OVERLAP(0)) u_nov (
        .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
        .F(f_nov), .S(s_nov), .count(cnt_nov)
    );

    machine_p #(.OVERLAP(1), .CNT_W(2)) u_sat (
        .CLK(CLK), .RESET(RESET), .x(x), .en(en), .clr_cnt(clr_cnt),
        .F(f_sat), .S(s_sat), .count(cnt_sat)
    );

    // Drive on the falling edge, consume one rising edge, sample 1 ns later.
    task automatic step(input logic xv, input logic env, input logic clrv, input logic rstv);
        @(negedge CLK);
        x       = xv;
        en      = env;
        clr_cnt = clrv;
        RESET   = rstv;
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (s_ov !== 3'd0 || f_ov !== 1'b0 || cnt_ov !== 8'd0) begin
            errors++;
            $display("FAIL reset_ov got S=%0d F=%b cnt=%0d want S=0 F=0 cnt=0", s_ov, f_ov, cnt_ov);
        end
        checks++;
        if (s_nov !== 3'd0 || f_nov !== 1'b0 || cnt_nov !== 8'd0) begin
            errors++;
            $display("FAIL reset_nov got S=%0d F=%b cnt=%0d want S=0 F=0 cnt=0", s_nov, f_nov, cnt_nov);
        end
        checks++;
        if (s_sat !== 3'd0 || f_sat !== 1'b0 || cnt_sat !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat got S=%0d F=%b cnt=%0d want S=0 F=0 cnt=0", s_sat, f_sat, cnt_sat);
        end
    endtask

    task automatic test_overlap();
        logic       xs    [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic [2:0] exp_s [7] = '{1, 2, 3, 4, 2, 3, 4};
        logic       exp_f [7] = '{0, 0, 0, 1, 0, 0, 1};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(xs[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (s_ov !== exp_s[i] || f_ov !== exp_f[i]) begin
                errors++;
                $display("FAIL overlap_edge%0d got S=%0d F=%b want S=%0d F=%b",
                         i + 1, s_ov, f_ov, exp_s[i], exp_f[i]);
            end
        end
        checks++;
        if (cnt_ov !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count got %0d want 2", cnt_ov);
        end
    endtask

    task automatic test_non_overlap();
        logic       xs    [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic [2:0] exp_s [7] = '{1, 2, 3, 4, 1, 0, 1};
        logic       exp_f [7] = '{0, 0, 0, 1, 0, 0, 0};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(xs[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (s_nov !== exp_s[i] || f_nov !== exp_f[i]) begin
                errors++;
                $display("FAIL nonoverlap_edge%0d got S=%0d F=%b want S=%0d F=%b",
                         i + 1, s_nov, f_nov, exp_s[i], exp_f[i]);
            end
        end
        checks++;
        if (cnt_nov !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_count got %0d want 1", cnt_nov);
        end
    endtask

    task automatic test_fallback_en();
        logic       xs    [8] = '{1, 1, 1, 0, 1, 0, 0, 1};
        logic       ens   [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        logic [2:0] exp_s [8] = '{1, 2, 2, 2, 2, 2, 3, 4};
        logic       exp_f [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(xs[i], ens[i], 1'b0, 1'b0);
            checks++;
            if (s_ov !== exp_s[i] || f_ov !== exp_f[i]) begin
                errors++;
                $display("FAIL fallback_edge%0d got S=%0d F=%b want S=%0d F=%b",
                         i + 1, s_ov, f_ov, exp_s[i], exp_f[i]);
            end
        end
        checks++;
        if (cnt_ov !== 8'd1) begin
            errors++;
            $display("FAIL fallback_count got %0d want 1", cnt_ov);
        end
        // en=0 must also freeze F high and the count
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_ov !== 3'd4 || f_ov !== 1'b1 || cnt_ov !== 8'd1) begin
            errors++;
            $display("FAIL en_hold got S=%0d F=%b cnt=%0d want S=4 F=1 cnt=1", s_ov, f_ov, cnt_ov);
        end
    endtask

    task automatic test_saturation();
        logic       pat  [4] = '{1, 1, 0, 1};
        logic [1:0] exp_c[4] = '{1, 2, 3, 3};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int d = 0; d < 4; d++) begin
            for (int b = 0; b < 4; b++) step(pat[b], 1'b1, 1'b0, 1'b0);
            checks++;
            if (cnt_sat !== exp_c[d] || f_sat !== 1'b1) begin
                errors++;
                $display("FAIL sat_detect%0d got cnt=%0d F=%b want cnt=%0d F=1",
                         d + 1, cnt_sat, f_sat, exp_c[d]);
            end
        end
        // From S=4, x=0 leads to S=0 with no detection: clear alone
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt_sat !== 2'd0 || s_sat !== 3'd0 || f_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got cnt=%0d S=%0d F=%b want cnt=0 S=0 F=0", cnt_sat, s_sat, f_sat);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt_sat !== 2'd1 || s_sat !== 3'd4 || f_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear_hit got cnt=%0d S=%0d F=%b want cnt=1 S=4 F=1", cnt_sat, s_sat, f_sat);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (s_ov !== 3'd3 || cnt_ov !== 8'd1) begin
            errors++;
            $display("FAIL mid_setup got S=%0d cnt=%0d want S=3 cnt=1", s_ov, cnt_ov);
        end
        // A RESET pulse entirely between edges must have no effect
        @(negedge CLK);
        en = 1'b0;
        #1 RESET = 1'b1;
        #2 RESET = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (s_ov !== 3'd3 || cnt_ov !== 8'd1) begin
            errors++;
            $display("FAIL mid_glitch got S=%0d cnt=%0d want S=3 cnt=1", s_ov, cnt_ov);
        end
        // x=1 would complete the pattern; RESET must win
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (s_ov !== 3'd0 || f_ov !== 1'b0 || cnt_ov !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset got S=%0d F=%b cnt=%0d want S=0 F=0 cnt=0", s_ov, f_ov, cnt_ov);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_fallback_en();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
